// File: rtl/cdc_bus_handshake_synch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cdc_bus_handshake_synch                                      |
// | Description : Closed-loop toggle req/ack crossing of a multi-bit status    |
// |               bus from clk_in to clk_out; only the latest value is sent.   |
// |               Optional periodic resend: CDC_BUS_SYNCH_REFRESH_EN.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cdc_bus_handshake_synch #(
    parameter int DATA_W         = 64,
    parameter int SYNC_STAGES    = 2,
    parameter int REFRESH_CYCLES = 1024
) (
    input  logic              clk_in,
    input  logic              reset_n_clk_in,
    input  logic              clk_out,
    input  logic              reset_n_clk_out,
    input  logic [DATA_W-1:0] data_in,
    input  logic              force_send,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid
);

    localparam logic [0:0] c_ST_IDLE     = 1'b0;
    localparam logic [0:0] c_ST_WAIT_ACK = 1'b1;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_chk_sync_stages
        $error("SYNC_STAGES must be in 2..4");
    end
    if (REFRESH_CYCLES < 16) begin : g_chk_refresh_cycles
        $error("REFRESH_CYCLES must be at least 16");
    end

    // clk_in domain
    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic                   w_send_req;
    logic                   w_ack_match;
    logic                   w_launch;
    logic                   w_ack_done;
    logic                   w_refresh_hit;
    logic                   r_req_tgl;
    logic [DATA_W-1:0]      r_hold_reg;
    logic [DATA_W-1:0]      r_last_sent;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   r_busy;
    logic                   r_force_pend;

    // clk_out domain
    logic [SYNC_STAGES-1:0] r_req_sync;
    logic                   w_req_edge;
    logic                   r_req_seen;
    logic                   r_ack_tgl;
    logic [DATA_W-1:0]      r_data_out;
    logic                   r_data_out_valid;

    assign w_send_req  = (data_in != r_last_sent) || r_force_pend;
    assign w_ack_match = (r_ack_sync[SYNC_STAGES-1] == r_req_tgl);

    always_ff @(posedge clk_in or negedge reset_n_clk_in) begin
        if (!reset_n_clk_in) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:     if (w_send_req)  w_state_nxt = c_ST_WAIT_ACK;
            c_ST_WAIT_ACK: if (w_ack_match) w_state_nxt = c_ST_IDLE;
            default:                        w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_launch   = 1'b0;
        w_ack_done = 1'b0;
        case (r_state)
            c_ST_IDLE:     w_launch   = w_send_req;
            c_ST_WAIT_ACK: w_ack_done = w_ack_match;
            default: begin
                w_launch   = 1'b0;
                w_ack_done = 1'b0;
            end
        endcase
    end

    // hold_reg only changes at launch, so it is stable for the whole handshake
    always_ff @(posedge clk_in or negedge reset_n_clk_in) begin
        if (!reset_n_clk_in) begin
            r_req_tgl    <= 1'b0;
            r_hold_reg   <= '0;
            r_last_sent  <= '0;
            r_busy       <= 1'b0;
            r_force_pend <= 1'b0;
            r_ack_sync   <= '0;
        end else begin
            r_ack_sync   <= {r_ack_sync[SYNC_STAGES-2:0], r_ack_tgl};
            r_force_pend <= force_send | w_refresh_hit | (r_force_pend & ~w_launch);
            if (w_launch) begin
                r_hold_reg <= data_in;
                r_req_tgl  <= ~r_req_tgl;
                r_busy     <= 1'b1;
            end
            if (w_ack_done) begin
                r_last_sent <= r_hold_reg;
                r_busy      <= 1'b0;
            end
        end
    end

`ifdef CDC_BUS_SYNCH_REFRESH_EN
    localparam int                 c_REF_W    = $clog2(REFRESH_CYCLES);
    localparam logic [c_REF_W-1:0] c_REF_LAST = c_REF_W'(REFRESH_CYCLES - 1);
    localparam logic [c_REF_W-1:0] c_REF_ONE  = c_REF_W'(1);

    logic [c_REF_W-1:0] r_refresh_cnt;

    // A launch restarts the interval; otherwise the counter free-runs and wraps
    always_ff @(posedge clk_in or negedge reset_n_clk_in) begin
        if (!reset_n_clk_in) begin
            r_refresh_cnt <= '0;
        end else if (w_launch || (r_refresh_cnt == c_REF_LAST)) begin
            r_refresh_cnt <= '0;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + c_REF_ONE;
        end
    end

    assign w_refresh_hit = !w_launch && (r_refresh_cnt == c_REF_LAST);
`else
    assign w_refresh_hit = 1'b0;
`endif

    assign busy = r_busy;

    assign w_req_edge = (r_req_sync[SYNC_STAGES-1] != r_req_seen);

    // Any req toggle, including one caused by a source reset, reloads data_out
    always_ff @(posedge clk_out or negedge reset_n_clk_out) begin
        if (!reset_n_clk_out) begin
            r_req_sync       <= '0;
            r_req_seen       <= 1'b0;
            r_ack_tgl        <= 1'b0;
            r_data_out       <= '0;
            r_data_out_valid <= 1'b0;
        end else begin
            r_req_sync       <= {r_req_sync[SYNC_STAGES-2:0], r_req_tgl};
            r_data_out_valid <= w_req_edge;
            if (w_req_edge) begin
                r_data_out <= r_hold_reg;
                r_req_seen <= r_req_sync[SYNC_STAGES-1];
                r_ack_tgl  <= r_req_sync[SYNC_STAGES-1];
            end
        end
    end

    assign data_out       = r_data_out;
    assign data_out_valid = r_data_out_valid;

endmodule
`default_nettype wire
